// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared sizes and types.
// The register file imports the same tag, register and data widths.
package reorder_buffer_pkg;

    localparam int ROB_ENTRIES = 64;
    localparam int LOC_W = 6;
    localparam int REG_W = 3;
    localparam int DATA_W = 16;
    localparam int CNT_W = LOC_W + 1;
    localparam int ALLOC_N = 4;
    localparam int CMP_N = 3;
    localparam int RET_N = 3;

    typedef logic [LOC_W-1:0] loc_t;
    typedef logic [REG_W-1:0] reg_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  wr;
        reg_t  dst;
        data_t data;
    } rob_entry_t;

    typedef struct packed {
        logic  wen;
        reg_t  addr;
        data_t data;
        loc_t  rob;
    } ret_port_t;

    // Rename only ever presents a prefix (A, AB, ABC, ABCD) of slots.
    function automatic logic [2:0] prefix_len(input logic [3:0] en);
        logic [2:0] n;
        n = 3'd0;
        if (en[0]) begin
            n = 3'd1;
            if (en[1]) begin
                n = 3'd2;
                if (en[2]) begin
                    n = 3'd3;
                    if (en[3]) n = 3'd4;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename, completion and retirement signals of the reorder buffer.
// Master is the core side; slave is the ROB itself.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic [ALLOC_N-1:0] alloc_en;
    logic [ALLOC_N-1:0] alloc_wr;
    reg_t [ALLOC_N-1:0] alloc_dst;
    loc_t [ALLOC_N-1:0] alloc_loc;
    logic               alloc_ready;

    logic  [CMP_N-1:0] cmp_en;
    loc_t  [CMP_N-1:0] cmp_loc;
    data_t [CMP_N-1:0] cmp_data;

    logic  [RET_N-1:0] wen;
    reg_t  [RET_N-1:0] waddr;
    data_t [RET_N-1:0] wdata;
    loc_t  [RET_N-1:0] wrob;

    modport master (
        output alloc_en, alloc_wr, alloc_dst,
        output cmp_en, cmp_loc, cmp_data,
        input  alloc_loc, alloc_ready,
        input  wen, waddr, wdata, wrob
    );

    modport slave (
        input  alloc_en, alloc_wr, alloc_dst,
        input  cmp_en, cmp_loc, cmp_data,
        output alloc_loc, alloc_ready,
        output wen, waddr, wdata, wrob
    );

endinterface

// File: rtl/rob_retire_scan.sv
// Picks the in-order run of finished entries at the head (0-3)
// and maps each onto a register-file write port.
module rob_retire_scan
    import reorder_buffer_pkg::*;
(
    input  rob_entry_t [RET_N-1:0] ent,
    input  loc_t                   head,
    output logic [1:0]             cnt,
    output ret_port_t [RET_N-1:0]  port
);

    logic [RET_N-1:0] take;

    always_comb begin
        take    = '0;
        take[0] = ent[0].valid & ent[0].done;
        take[1] = take[0] & ent[1].valid & ent[1].done;
        take[2] = take[1] & ent[2].valid & ent[2].done;
    end

    assign cnt = 2'(take[0]) + 2'(take[1]) + 2'(take[2]);

    always_comb begin
        port = '0;
        for (int k = 0; k < RET_N; k++) begin
            if (take[k]) begin
                port[k].wen  = ent[k].wr;
                port[k].addr = ent[k].dst;
                port[k].data = ent[k].data;
                port[k].rob  = head + LOC_W'(k);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at the tail, captures
// results by tag and retires up to three finished entries per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             reset,
    input logic             flush,
    reorder_buffer_if.slave bus
);

    rob_entry_t mem [ROB_ENTRIES];

    loc_t head;
    loc_t tail;
    cnt_t count;

    logic [2:0] n_alloc;
    logic [1:0] n_ret;

    rob_entry_t [RET_N-1:0] scan_ent;
    ret_port_t  [RET_N-1:0] scan_port;

    // Gated on the start-of-cycle count; same-cycle retires do not help.
    assign bus.alloc_ready =
        (count <= cnt_t'(ROB_ENTRIES - ALLOC_N));

    assign n_alloc = bus.alloc_ready
                   ? prefix_len(bus.alloc_en) : 3'd0;

    always_comb begin
        bus.alloc_loc = '0;
        for (int k = 0; k < ALLOC_N; k++) begin
            bus.alloc_loc[k] = tail + LOC_W'(k);
        end
    end

    always_comb begin
        scan_ent = '0;
        for (int k = 0; k < RET_N; k++) begin
            scan_ent[k] = mem[head + LOC_W'(k)];
        end
    end

    rob_retire_scan u_scan (
        .ent  (scan_ent),
        .head (head),
        .cnt  (n_ret),
        .port (scan_port)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                mem[i] <= '0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            bus.wen   <= '0;
            bus.waddr <= '0;
            bus.wdata <= '0;
            bus.wrob  <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
                mem[i].done  <= 1'b0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            bus.wen <= '0;
        end else begin
            // Invalid targets cover stale tags left over from a flush.
            for (int p = 0; p < CMP_N; p++) begin
                if (bus.cmp_en[p] && mem[bus.cmp_loc[p]].valid) begin
                    mem[bus.cmp_loc[p]].done <= 1'b1;
                    mem[bus.cmp_loc[p]].data <= bus.cmp_data[p];
                end
            end
            for (int k = 0; k < RET_N; k++) begin
                if (2'(k) < n_ret) begin
                    mem[head + LOC_W'(k)].valid <= 1'b0;
                    mem[head + LOC_W'(k)].done  <= 1'b0;
                end
            end
            for (int k = 0; k < ALLOC_N; k++) begin
                if (3'(k) < n_alloc) begin
                    mem[tail + LOC_W'(k)] <= '{
                        valid: 1'b1,
                        done:  1'b0,
                        wr:    bus.alloc_wr[k],
                        dst:   bus.alloc_dst[k],
                        data:  '0
                    };
                end
            end
            head  <= head + LOC_W'(n_ret);
            tail  <= tail + LOC_W'(n_alloc);
            count <= count + cnt_t'(n_alloc) - cnt_t'(n_ret);
            for (int k = 0; k < RET_N; k++) begin
                bus.wen[k]   <= scan_port[k].wen;
                bus.waddr[k] <= scan_port[k].addr;
                bus.wdata[k] <= scan_port[k].data;
                bus.wrob[k]  <= scan_port[k].rob;
            end
        end
    end

endmodule
